neuron_wt_streamer: RTL and testbench

//  Transmit side of the neuron weight-update port. Holds the NUM_IP weights of one neuron.
//  On each backprop step it computes w_new = w - (grad >>> LR_SHIFT).
//  It then drives update_wts for exactly NUM_IP consecutive cycles, so the neuron's free-running wt_count walks indices 0..NUM_IP-1 once and wraps.
//  One instance per neuron; it sits between the gradient engine and the neuron.

---
 rtl/cnn_pkg.sv | 21 ++
 rtl/wt_sat_sub.sv | 38 +++
 rtl/neuron_wt_streamer.sv | 144 ++++++++++++++
 tb/tb_neuron_wt_streamer.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared types for the neuron weight-update path: weight/accumulator widths,
// streamer FSM states and the weight sign-extension helper.
package cnn_pkg;

  localparam int CNN_IP_DATA_WIDTH = 8;

  typedef logic signed [CNN_IP_DATA_WIDTH-1:0]   wt_t;
  typedef logic signed [2*CNN_IP_DATA_WIDTH-1:0] acc_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    STREAM  = 2'd2,
    DONE    = 2'd3
  } wts_state_e;

  function automatic acc_t wt_sext(input wt_t w);
    return {{CNN_IP_DATA_WIDTH{w[CNN_IP_DATA_WIDTH-1]}}, w};
  endfunction

endpackage

// File: rtl/wt_sat_sub.sv
// Combinational weight update w - (g >>> LR_SHIFT) at 2W+1 bits, reduced to W bits.
// WT_SAT_EN selects clamping; otherwise the result wraps (two's complement).
module wt_sat_sub #(
  parameter int W        = 8,
  parameter int LR_SHIFT = 3
) (
  input  logic signed [W-1:0]   w,
  input  logic signed [2*W-1:0] g,
  output logic signed [W-1:0]   res
);

  logic signed [2*W-1:0] g_sh;
  logic signed [2*W:0]   diff;

  assign g_sh = g >>> LR_SHIFT;
  // Both operands widened by sign so the difference cannot overflow.
  assign diff = {{(W+1){w[W-1]}}, w} - {g_sh[2*W-1], g_sh};

`ifdef WT_SAT_EN
  localparam logic signed [2*W:0] MAXV = {{(W+2){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [2*W:0] MINV = {{(W+2){1'b1}}, {(W-1){1'b0}}};

  always_comb begin
    res = diff[W-1:0];
    if (diff > MAXV) begin
      res = MAXV[W-1:0];
    end else if (diff < MINV) begin
      res = MINV[W-1:0];
    end
  end
`else
  logic [W:0] unused_hi;

  assign unused_hi = diff[2*W:W];
  assign res       = diff[W-1:0];
`endif

endmodule

// File: rtl/neuron_wt_streamer.sv
// Weight-update transmitter for one neuron: applies a gradient step to NUM_IP weights,
// then drives update_wts for exactly NUM_IP cycles. Build option: WT_SAT_EN (saturating update).
module neuron_wt_streamer
  import cnn_pkg::*;
#(
  parameter int IP_DATA_WIDTH = 8,
  parameter int NUM_IP        = 8,
  parameter int LR_SHIFT      = 3
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      init_load,
  input  logic [NUM_IP-1:0][IP_DATA_WIDTH-1:0]      init_wt,
  input  logic                                      start,
  input  logic [NUM_IP-1:0][2*IP_DATA_WIDTH-1:0]    grad_in,
  output logic [NUM_IP-1:0][2*IP_DATA_WIDTH-1:0]    wt_out,
  output logic                                      update_wts,
  output logic                                      busy,
  output logic                                      done
);

  localparam int IDX_W = (NUM_IP > 1) ? $clog2(NUM_IP) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_IP - 1);

  wts_state_e                       state_q, state_d;
  logic [IDX_W-1:0]                 idx_q, idx_d;
  logic signed [IP_DATA_WIDTH-1:0]  wt_q   [NUM_IP];
  logic signed [2*IP_DATA_WIDTH-1:0] grad_q [NUM_IP];
  logic                             update_wts_q, update_wts_d;
  logic                             done_q, done_d;
  logic                             load_init, start_ok, compute_en;
  logic signed [IP_DATA_WIDTH-1:0]  sub_w, sub_res;
  logic signed [2*IP_DATA_WIDTH-1:0] sub_g;

  // init_load has priority over start; both are only honoured in IDLE.
  assign load_init  = (state_q == IDLE) && init_load;
  assign start_ok   = (state_q == IDLE) && start && !init_load;
  assign compute_en = (state_q == COMPUTE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        idx_d = '0;
        if (start_ok) state_d = COMPUTE;
      end
      COMPUTE: begin
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = STREAM;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      STREAM: begin
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        idx_d   = '0;
        state_d = IDLE;
      end
      default: begin
        idx_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    update_wts_d = (state_d == STREAM);
    done_d       = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      update_wts_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      update_wts_q <= update_wts_d;
      done_q       <= done_d;
    end
  end

  assign update_wts = update_wts_q;
  assign done       = done_q;
  assign busy       = (state_q == COMPUTE) || (state_q == STREAM);

  // One shared update datapath, walked across the weights by idx during COMPUTE.
  assign sub_w = wt_q[idx_q];
  assign sub_g = grad_q[idx_q];

  wt_sat_sub #(
    .W        (IP_DATA_WIDTH),
    .LR_SHIFT (LR_SHIFT)
  ) u_wt_sat_sub (
    .w   (sub_w),
    .g   (sub_g),
    .res (sub_res)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NUM_IP; gi++) begin : g_lane
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          wt_q[gi]   <= '0;
          grad_q[gi] <= '0;
        end else begin
          if (load_init) begin
            wt_q[gi] <= init_wt[gi];
          end else if (compute_en && (idx_q == IDX_W'(gi))) begin
            wt_q[gi] <= sub_res;
          end
          if (start_ok) begin
            grad_q[gi] <= grad_in[gi];
          end
        end
      end

      if (IP_DATA_WIDTH == CNN_IP_DATA_WIDTH) begin : g_pkg_sext
        assign wt_out[gi] = wt_sext(wt_q[gi]);
      end else begin : g_gen_sext
        assign wt_out[gi] = {{IP_DATA_WIDTH{wt_q[gi][IP_DATA_WIDTH-1]}}, wt_q[gi]};
      end
    end
  endgenerate

endmodule

// File: tb/tb_neuron_wt_streamer.sv
// Directed, table-driven bench for neuron_wt_streamer (W=8, NUM_IP=8, LR_SHIFT=3).
// Expected values follow the WT_SAT_EN build option.
module tb_neuron_wt_streamer;

  localparam int W  = 8;
  localparam int N  = 8;
  localparam int LR = 3;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  init_load = 1'b0;
  logic                  start = 1'b0;
  logic [N-1:0][W-1:0]   init_wt;
  logic [N-1:0][2*W-1:0] grad_in;
  logic [N-1:0][2*W-1:0] wt_out;
  logic                  update_wts, busy, done;

  int checks = 0;
  int passed = 0;
  int nrn_idx = 0;

  always #5 clk = ~clk;

  neuron_wt_streamer #(
    .IP_DATA_WIDTH (W),
    .NUM_IP        (N),
    .LR_SHIFT      (LR)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .init_load  (init_load),
    .init_wt    (init_wt),
    .start      (start),
    .grad_in    (grad_in),
    .wt_out     (wt_out),
    .update_wts (update_wts),
    .busy       (busy),
    .done       (done)
  );

  typedef struct {
    string       name;
    logic [7:0]  w;
    logic [15:0] g;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic set_all(input logic [7:0] w, input logic [15:0] g);
    for (int i = 0; i < N; i++) begin
      init_wt[i] = w;
      grad_in[i] = g;
    end
  endtask

  task automatic load_weights();
    @(posedge clk); #1 init_load = 1'b1;
    @(posedge clk); #1 init_load = 1'b0;
  endtask

  // One full step; optionally pokes start/init_load during COMPUTE.
  task automatic run_step(input string name, input logic [15:0] exp, input bit poke);
    int first = 0, cnt = 0, done_at = 0, busy_cnt = 0, unstable = 0, bad_idx = 0;
    int seen[N];
    logic [N-1:0][2*W-1:0] snap;
    for (int i = 0; i < N; i++) seen[i] = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int i = 0; i < N; i++) grad_in[i] = 16'hA5A5;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      if (poke && k == 3) begin
        start = 1'b1; init_load = 1'b1;
        for (int i = 0; i < N; i++) init_wt[i] = 8'd55;
      end else if (poke && k == 4) begin
        start = 1'b0; init_load = 1'b0;
      end
      if (busy) busy_cnt++;
      if (update_wts) begin
        if (first == 0) begin
          first = k;
          snap = wt_out;
        end else if (wt_out != snap) unstable++;
        cnt++;
        seen[nrn_idx]++;
        nrn_idx = (nrn_idx + 1) % N;
      end
      if (done && done_at == 0) done_at = k;
    end
    for (int i = 0; i < N; i++) if (seen[i] != 1) bad_idx++;
    $display("step %s: first=%0d len=%0d done_at=%0d wt_out[0]=0x%04h", name, first, cnt,
             done_at, wt_out[0]);
    check({name, " first_update"}, first, 9);
    check({name, " update_len"}, cnt, 8);
    check({name, " done_at"}, done_at, 17);
    check({name, " busy_cycles"}, busy_cnt, 16);
    check({name, " stable"}, unstable, 0);
    check({name, " neuron_idx_once"}, bad_idx, 0);
    check({name, " neuron_wrap"}, nrn_idx, 0);
    for (int i = 0; i < N; i++) check($sformatf("%s wt_out[%0d]", name, i), wt_out[i], exp);
  endtask

  initial begin
    int act;
    vecs[0] = '{"basic",    8'd10,  16'd16,   16'h0008};
    vecs[1] = '{"neg",      8'hFB,  16'd24,   16'hFFF8};
`ifdef WT_SAT_EN
    vecs[2] = '{"sat_hi",   8'd127, 16'hFFB0, 16'h007F};
    vecs[3] = '{"sat_lo",   8'h80,  16'd8,    16'hFF80};
    vecs[5] = '{"big_grad", 8'd100, 16'h7FFF, 16'hFF80};
`else
    vecs[2] = '{"sat_hi",   8'd127, 16'hFFB0, 16'hFF89};
    vecs[3] = '{"sat_lo",   8'h80,  16'd8,    16'h007F};
    vecs[5] = '{"big_grad", 8'd100, 16'h7FFF, 16'h0065};
`endif
    vecs[4] = '{"neg_grad", 8'd0,   16'hFFF9, 16'h0001};
    vecs[6] = '{"to_zero",  8'hFF,  16'hFFF8, 16'h0000};

    set_all(8'd0, 16'd0);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset outputs", {update_wts, busy, done, 1'b0}, 4'b0);
    check("reset wt_out", (wt_out == '0), 1);
    @(posedge clk); #1 rst_n = 1'b1;
    act = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (update_wts || busy || done || wt_out != '0) act++;
    end
    check("idle activity", act, 0);

    for (int v = 0; v < 7; v++) begin
      set_all(vecs[v].w, vecs[v].g);
      load_weights();
      run_step(vecs[v].name, vecs[v].exp, 1'b0);
    end

    // init_load + start together: load wins, no stream
    set_all(8'd20, 16'd16);
    @(posedge clk); #1 init_load = 1'b1; start = 1'b1;
    @(posedge clk); #1 init_load = 1'b0; start = 1'b0;
    act = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (update_wts || busy || done) act++;
    end
    $display("collision: activity=%0d wt_out[0]=0x%04h", act, wt_out[0]);
    check("collision no_stream", act, 0);
    check("collision loaded", wt_out[0], 16'h0014);

    // pokes mid-COMPUTE ignored: 20 - (16>>>3) = 18
    set_all(8'd20, 16'd16);
    run_step("poke", 16'h0012, 1'b1);

    // reset on 3rd update_wts cycle
    set_all(8'd10, 16'd16);
    load_weights();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    act = 0;
    for (int k = 0; k < 30 && act < 3; k++) begin
      @(negedge clk);
      if (update_wts) act++;
    end
    check("reach 3rd update", act, 3);
    rst_n = 1'b0;
    #1;
    $display("reset mid-stream: update_wts=%0b busy=%0b", update_wts, busy);
    check("midrst update_wts", update_wts, 0);
    check("midrst busy", busy, 0);
    check("midrst wt_out", (wt_out == '0), 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    nrn_idx = 0;  // neuron re-aligned by the system
    load_weights();
    run_step("after_rst", 16'h0008, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
